// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : 32 x XLEN integer register file with two combinational read
//            ports (same-cycle writeback bypass), a per-register pending-write
//            scoreboard, the decode stall for RAW/WAW hazards, and a sticky
//            error flag for writebacks that nothing was waiting for.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  // writeback port
  input  logic            rd_en,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  // decode read ports
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  // issue handshake
  input  logic            issue_valid_i,
  input  logic            issue_use_rs1_i,
  input  logic            issue_use_rs2_i,
  input  logic            issue_rd_en_i,
  input  logic [4:0]      issue_rd_addr_i,
  output logic            stall_o,
  output logic            issue_fire_o,
  output logic            wb_err_o
);

  localparam logic [PEND_W-1:0] c_CNT_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] c_CNT_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] c_CNT_ZERO = '0;

  logic [XLEN-1:0]   r_regs [NREG];
  logic [PEND_W-1:0] r_cnt  [NREG];
  logic              r_wb_err;

  logic [NREG-1:0]   w_busy;
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;
  logic              w_wb_live;
  logic              w_rd_full;
  logic              w_wb_orphan;

  // A writeback to x0 is discarded completely.
  assign w_wb_live = rd_en && (rd_addr_i != 5'd0);

  // Read port 1: x0 reads zero, then bypass, then the stored value.
  always_comb begin
    rs1_data_o = r_regs[rs1_addr_i];
    if (rs1_addr_i == 5'd0)
      rs1_data_o = '0;
    else if (rd_en && (rd_addr_i == rs1_addr_i))
      rs1_data_o = rd_data_i;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rs2_data_o = r_regs[rs2_addr_i];
    if (rs2_addr_i == 5'd0)
      rs2_data_o = '0;
    else if (rd_en && (rd_addr_i == rs2_addr_i))
      rs2_data_o = rd_data_i;
  end

  // Busy: pending writes remain after this cycle's retirement (x0 never busy).
  always_comb begin
    w_busy = '0;
    for (int r = 1; r < NREG; r++) begin
      w_busy[r] = (r_cnt[r] != c_CNT_ZERO) &&
                  !(rd_en && (rd_addr_i == 5'(r)) && (r_cnt[r] == c_CNT_ONE));
    end
  end

  // Destination counter full: one more in-flight write would wrap it. Uses the
  // pre-edge count, so a retiring write this cycle does not release the stall.
  assign w_rd_full = issue_rd_en_i && (issue_rd_addr_i != 5'd0) &&
                     (r_cnt[issue_rd_addr_i] == c_CNT_MAX);

  // Decode stall and issue acceptance.
  always_comb begin
    stall_o = issue_valid_i &&
              ((issue_use_rs1_i && w_busy[rs1_addr_i]) ||
               (issue_use_rs2_i && w_busy[rs2_addr_i]) ||
               w_rd_full);
    issue_fire_o = issue_valid_i && !stall_o;
  end

  // Per-register increment (accepted issue) and decrement (retiring writeback).
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 1; r < NREG; r++) begin
      w_inc[r] = issue_fire_o && issue_rd_en_i && (issue_rd_addr_i == 5'(r));
      w_dec[r] = rd_en && (rd_addr_i == 5'(r)) && (r_cnt[r] != c_CNT_ZERO);
    end
  end

  // A writeback with no pending write behind it is a protocol error.
  assign w_wb_orphan = w_wb_live && (r_cnt[rd_addr_i] == c_CNT_ZERO);

  // Register array: reset clears everything, writeback updates one entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else if (w_wb_live) begin
      r_regs[rd_addr_i] <= rd_data_i;
    end
  end

  // Pending-write counters; simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r])
          r_cnt[r] <= r_cnt[r] + c_CNT_ONE;
        else if (w_dec[r] && !w_inc[r])
          r_cnt[r] <= r_cnt[r] - c_CNT_ONE;
      end
    end
  end

  // Sticky writeback error flag.
  always_ff @(posedge clk) begin
    if (reset)
      r_wb_err <= 1'b0;
    else if (w_wb_orphan)
      r_wb_err <= 1'b1;
  end

  assign wb_err_o = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed self-checking bench for regfile_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        issue_valid_i;
  logic        issue_use_rs1_i;
  logic        issue_use_rs2_i;
  logic        issue_rd_en_i;
  logic [4:0]  issue_rd_addr_i;
  logic        stall_o;
  logic        issue_fire_o;
  logic        wb_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_scoreboard #(.XLEN(32), .NREG(32), .PEND_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .rd_en           (rd_en),
    .rd_addr_i       (rd_addr_i),
    .rd_data_i       (rd_data_i),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_addr_i      (rs2_addr_i),
    .rs1_data_o      (rs1_data_o),
    .rs2_data_o      (rs2_data_o),
    .issue_valid_i   (issue_valid_i),
    .issue_use_rs1_i (issue_use_rs1_i),
    .issue_use_rs2_i (issue_use_rs2_i),
    .issue_rd_en_i   (issue_rd_en_i),
    .issue_rd_addr_i (issue_rd_addr_i),
    .stall_o         (stall_o),
    .issue_fire_o    (issue_fire_o),
    .wb_err_o        (wb_err_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change 1 ns after the edge, checks 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; rd_en = 1'b0; rd_addr_i = '0; rd_data_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0;
    issue_valid_i = 1'b0; issue_use_rs1_i = 1'b0; issue_use_rs2_i = 1'b0;
    issue_rd_en_i = 1'b0; issue_rd_addr_i = '0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    issue_valid_i = 1'b1; issue_rd_en_i = 1'b1; issue_rd_addr_i = rd;
    issue_use_rs1_i = 1'b0; issue_use_rs2_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'(31 - i);
      settle();
      n_cmp++;
      if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_read x%0d: got %h/%h want 0/0", i, rs1_data_o, rs2_data_o);
      end
    end
    n_cmp++;
    if (wb_err_o !== 1'b0 || stall_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: err=%b stall=%b want 0/0", wb_err_o, stall_o);
    end
    // Writeback to x0 is ignored, even on the bypass path.
    rd_en = 1'b1; rd_addr_i = 5'd0; rd_data_i = 32'hDEADBEEF; rs1_addr_i = 5'd0;
    settle();
    n_cmp++;
    if (rs1_data_o !== 32'h0) begin
      n_bad++; $display("FAIL x0_bypass: got %h want 0", rs1_data_o);
    end
    tick();
    idle();
    settle();
    n_cmp++;
    if (rs1_data_o !== 32'h0 || wb_err_o !== 1'b0) begin
      n_bad++; $display("FAIL x0_write: data=%h err=%b want 0/0", rs1_data_o, wb_err_o);
    end
    // Issuing a write to x0 never creates a hazard on x0.
    issue_wr(5'd0);
    tick();
    idle();
    issue_valid_i = 1'b1; issue_use_rs1_i = 1'b1; rs1_addr_i = 5'd0;
    settle();
    n_cmp++;
    if (stall_o !== 1'b0 || issue_fire_o !== 1'b1) begin
      n_bad++; $display("FAIL x0_busy: stall=%b fire=%b want 0/1", stall_o, issue_fire_o);
    end
    tick();
    idle();
  endtask

  task automatic test_raw();
    issue_wr(5'd5);
    settle();
    n_cmp++;
    if (issue_fire_o !== 1'b1) begin
      n_bad++; $display("FAIL raw_issue: fire=%b want 1", issue_fire_o);
    end
    tick();
    idle();
    issue_valid_i = 1'b1; issue_use_rs1_i = 1'b1; rs1_addr_i = 5'd5;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_cmp++;
      if (stall_o !== 1'b1 || issue_fire_o !== 1'b0) begin
        n_bad++; $display("FAIL raw_stall c%0d: stall=%b fire=%b want 1/0", c, stall_o, issue_fire_o);
      end
      tick();
    end
    rd_en = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'h00001234;
    settle();
    n_cmp++;
    if (stall_o !== 1'b0 || issue_fire_o !== 1'b1 || rs1_data_o !== 32'h00001234) begin
      n_bad++;
      $display("FAIL raw_release: stall=%b fire=%b data=%h want 0/1/00001234", stall_o, issue_fire_o, rs1_data_o);
    end
    tick();
    idle();
    issue_valid_i = 1'b1; issue_use_rs2_i = 1'b1; rs2_addr_i = 5'd5; rs1_addr_i = 5'd5;
    settle();
    n_cmp++;
    if (stall_o !== 1'b0 || rs1_data_o !== 32'h00001234 || rs2_data_o !== 32'h00001234 || wb_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL raw_after: stall=%b d1=%h d2=%h err=%b want 0/00001234/00001234/0", stall_o, rs1_data_o, rs2_data_o, wb_err_o);
    end
    tick();
    idle();
  endtask

  task automatic test_waw_saturate();
    for (int k = 0; k < 3; k++) begin
      issue_wr(5'd7);
      settle();
      n_cmp++;
      if (issue_fire_o !== 1'b1) begin
        n_bad++; $display("FAIL waw_fill k%0d: fire=%b want 1", k, issue_fire_o);
      end
      tick();
    end
    // Fourth writer of x7 with a same-cycle writeback: stall uses pre-edge count.
    issue_wr(5'd7);
    rd_en = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'h77770001;
    settle();
    n_cmp++;
    if (stall_o !== 1'b1 || issue_fire_o !== 1'b0) begin
      n_bad++; $display("FAIL waw_full: stall=%b fire=%b want 1/0", stall_o, issue_fire_o);
    end
    tick();
    rd_en = 1'b0;
    settle();
    n_cmp++;
    if (stall_o !== 1'b0 || issue_fire_o !== 1'b1) begin
      n_bad++; $display("FAIL waw_resume: stall=%b fire=%b want 0/1", stall_o, issue_fire_o);
    end
    tick();
    // Count is back to 3; drain it with three writebacks.
    idle();
    issue_valid_i = 1'b1; issue_use_rs1_i = 1'b1; rs1_addr_i = 5'd7;
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'h77770010 + 32'(k);
      settle();
      n_cmp++;
      if (stall_o !== (k < 2) || rs1_data_o !== 32'h77770010 + 32'(k)) begin
        n_bad++;
        $display("FAIL waw_drain k%0d: stall=%b data=%h want %b/%h", k, stall_o, rs1_data_o, (k < 2), 32'h77770010 + 32'(k));
      end
      tick();
    end
    rd_en = 1'b0;
    settle();
    n_cmp++;
    if (stall_o !== 1'b0 || rs1_data_o !== 32'h77770012 || wb_err_o !== 1'b0) begin
      n_bad++; $display("FAIL waw_done: stall=%b data=%h err=%b want 0/77770012/0", stall_o, rs1_data_o, wb_err_o);
    end
    tick();
    idle();
  endtask

  task automatic test_same_cycle();
    issue_wr(5'd9);
    tick();
    // Issue and writeback of x9 in one cycle: count stays at 1.
    issue_wr(5'd9);
    rd_en = 1'b1; rd_addr_i = 5'd9; rd_data_i = 32'h000000AA;
    settle();
    n_cmp++;
    if (issue_fire_o !== 1'b1) begin
      n_bad++; $display("FAIL same_fire: fire=%b want 1", issue_fire_o);
    end
    tick();
    idle();
    issue_valid_i = 1'b1; issue_use_rs2_i = 1'b1; rs2_addr_i = 5'd9;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_cmp++;
      if (stall_o !== 1'b1 || rs2_data_o !== 32'h000000AA) begin
        n_bad++; $display("FAIL same_stall c%0d: stall=%b data=%h want 1/000000aa", c, stall_o, rs2_data_o);
      end
      tick();
    end
    rd_en = 1'b1; rd_addr_i = 5'd9; rd_data_i = 32'h000000BB;
    settle();
    n_cmp++;
    if (stall_o !== 1'b0 || rs2_data_o !== 32'h000000BB) begin
      n_bad++; $display("FAIL same_release: stall=%b data=%h want 0/000000bb", stall_o, rs2_data_o);
    end
    tick();
    idle();
    settle();
    n_cmp++;
    if (wb_err_o !== 1'b0) begin
      n_bad++; $display("FAIL same_err: err=%b want 0", wb_err_o);
    end
  endtask

  task automatic test_wb_err();
    rd_en = 1'b1; rd_addr_i = 5'd12; rd_data_i = 32'hCAFEF00D;
    settle();
    n_cmp++;
    if (wb_err_o !== 1'b0) begin
      n_bad++; $display("FAIL err_early: err=%b want 0", wb_err_o);
    end
    tick();
    idle();
    rs1_addr_i = 5'd12;
    issue_valid_i = 1'b1; issue_use_rs1_i = 1'b1;
    settle();
    n_cmp++;
    if (wb_err_o !== 1'b1 || rs1_data_o !== 32'hCAFEF00D || stall_o !== 1'b0) begin
      n_bad++; $display("FAIL err_set: err=%b data=%h stall=%b want 1/cafef00d/0", wb_err_o, rs1_data_o, stall_o);
    end
    tick();
    idle();
    tick();
    n_cmp++;
    if (wb_err_o !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: err=%b want 1", wb_err_o);
    end
  endtask

  task automatic test_reset_pending();
    issue_wr(5'd3);
    tick();
    // Reset dominates a same-cycle issue and writeback.
    reset = 1'b1; rd_en = 1'b1; rd_addr_i = 5'd4; rd_data_i = 32'h44444444;
    tick();
    idle();
    issue_valid_i = 1'b1; issue_use_rs1_i = 1'b1; rs1_addr_i = 5'd3;
    issue_use_rs2_i = 1'b1; rs2_addr_i = 5'd4;
    settle();
    n_cmp++;
    if (stall_o !== 1'b0 || rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0 || wb_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pending: stall=%b d1=%h d2=%h err=%b want 0/0/0/0", stall_o, rs1_data_o, rs2_data_o, wb_err_o);
    end
    tick();
    idle();
    rs1_addr_i = 5'd5; rs2_addr_i = 5'd12;
    settle();
    n_cmp++;
    if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_clear: d1=%h d2=%h want 0/0", rs1_data_o, rs2_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw_saturate();
    test_same_cycle();
    test_wb_err();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Consumer end of the writeback interface: accepts the `rd_en` / `rd_addr` / `rd_data` write port driven by the writeback stage.
- Holds the 32 x 32-bit integer register file.
- Serves two combinational read ports to decode, with same-cycle write bypass.
- Tracks pending writes per register (scoreboard) and produces the decode stall for read-after-write and write-after-write hazards.

Parameters:
- XLEN, 32, register data width
- NREG, 32, number of architectural registers; x0 hardwired to zero
- PEND_W, 2, width of per-register pending-write counter; at most 2^PEND_W-1 in-flight writes per register

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- rd_en  input  1  writeback strobe from writeback stage
- rd_addr_i  input  5  writeback destination register
- rd_data_i  input  XLEN  writeback data
- rs1_addr_i  input  5  read port 1 address
- rs2_addr_i  input  5  read port 2 address
- rs1_data_o  output  XLEN  read port 1 data (combinational)
- rs2_data_o  output  XLEN  read port 2 data (combinational)
- issue_valid_i  input  1  decode presents an instruction for issue
- issue_use_rs1_i  input  1  instruction reads rs1
- issue_use_rs2_i  input  1  instruction reads rs2
- issue_rd_en_i  input  1  instruction will write rd
- issue_rd_addr_i  input  5  destination of issuing instruction
- stall_o  output  1  decode must hold; issue not accepted this cycle (combinational)
- issue_fire_o  output  1  issue_valid_i && !stall_o
- wb_err_o  output  1  sticky: writeback arrived for a register with no pending write

Behaviour:
- Reset (clk edge with reset=1):
  - all registers cleared to 0; all pending counters 0; wb_err_o = 0.
  - Reset dominates any same-cycle rd_en or issue; in-flight pending state is discarded.
- Write:
  - on posedge, if rd_en && rd_addr_i != 0, reg[rd_addr_i] <= rd_data_i.
  - Writes to x0 are ignored entirely: no data written, no counter change, no error.
- Read:
  - rsN_data_o = 0 if rsN_addr_i == 0.
  - Otherwise rd_data_i if rd_en && rd_addr_i == rsN_addr_i (bypass).
  - Otherwise reg[rsN_addr_i].
- Busy:
  - busy(r) = (cnt[r] != 0) unless rd_en && rd_addr_i == r && cnt[r] == 1, i.e. the last pending write is retiring this cycle.
  - x0 is never busy.
- Stall:
  - stall_o = issue_valid_i && ( (issue_use_rs1_i && busy(rs1_addr_i)) || (issue_use_rs2_i && busy(rs2_addr_i)) || (issue_rd_en_i && issue_rd_addr_i != 0 && cnt[issue_rd_addr_i] == max) ).
  - stall_o = 0 when issue_valid_i = 0.
- Counter update per register r != 0, each clock:
  - inc = issue_fire_o && issue_rd_en_i && issue_rd_addr_i == r.
  - dec = rd_en && rd_addr_i == r && cnt[r] != 0.
  - inc && !dec -> +1; dec && !inc -> -1; both -> unchanged.
  - Counter never wraps; saturation is prevented by the stall term.
- Error:
  - rd_en && rd_addr_i != 0 && cnt[rd_addr_i] == 0 sets wb_err_o (sticky until reset).
  - The data is still written; the counter stays 0.
- Latency:
  - Read path: 0 cycles.
  - Write is visible through the register array the cycle after rd_en, and through the bypass in the same cycle.
  - Pending-count effect of an issue is visible the next cycle.
- All decisions use pre-edge counter values; no combinational loop from stall_o to counters except via issue_fire_o.

Test Plan:
- Reset, then read x0..x31 -> all 0; assert rd_en=1, rd_addr=0, data=0xDEADBEEF -> x0 still reads 0, wb_err_o=0.
- Issue rd=x5 (fire), next cycle issue using rs1=x5 -> stall_o=1 until the cycle rd_en=1, rd_addr=5, data=0x1234 arrives. In that cycle: stall_o=0, rs1_data_o=0x1234 (bypass), issue fires.
- Issue rd=x7 three times (PEND_W=2) -> cnt=3; a fourth issue writing x7 -> stall_o=1. WB x7 in the same cycle -> stall stays 1 this cycle; next cycle cnt=2 and the issue fires.
- Same cycle: issue rd=x9 fires and WB to x9 with cnt[x9]=1 -> cnt stays 1; subsequent reader of x9 stalls until the next WB.
- rd_en=1, rd_addr=12 with cnt[12]=0 -> wb_err_o=1 next cycle, stays 1; x12 reads the written value.
- Issue rd=x3 fires, reset asserted next cycle -> cnt[3]=0, reader of x3 does not stall, x3 reads 0.
